// File: rtl/io_bus_arbiter.sv
// Two-master arbiter sharing the single-port IO register file bus between the
// CPU load/store path (master 0) and the DMA engine (master 1).
module io_bus_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk_mem,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_write,
  input  logic [1:0]        cpu_width,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_write,
  input  logic [1:0]        dma_width,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_read,
  output logic              bus_write,
  output logic [1:0]        bus_width,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER_CPU = 2'd1,
    XFER_DMA = 2'd2
  } state_t;

  state_t state;

  // Handshake: req is held until the one-cycle ack; the edge ending the ack
  // cycle completes the transfer. A master's own req is ignored in its own
  // XFER cycle, so grants alternate under contention and DMA wins from IDLE.
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dma_req)      state <= XFER_DMA;
          else if (cpu_req) state <= XFER_CPU;
          else              state <= IDLE;
        end
        XFER_CPU: state <= dma_req ? XFER_DMA : IDLE;
        XFER_DMA: state <= cpu_req ? XFER_CPU : IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state and the granted master's fields; reset clears
  // state asynchronously, so an aborted transfer drops its strobes at once.
  always_comb begin
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    cpu_rdata = '0;
    dma_rdata = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_width = 2'b00;
    case (state)
      XFER_CPU: begin
        cpu_ack   = 1'b1;
        cpu_rdata = bus_rdata;
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_read  = ~cpu_write;
        bus_write = cpu_write;
        bus_width = cpu_width;
      end
      XFER_DMA: begin
        dma_ack   = 1'b1;
        dma_rdata = bus_rdata;
        bus_addr  = dma_addr;
        bus_wdata = dma_wdata;
        bus_read  = ~dma_write;
        bus_write = dma_write;
        bus_width = dma_width;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: grant model, register-file model, per-cycle compare,
// directed literal checks and randomized two-master traffic.
module tb_io_bus_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  logic              clk_mem = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0, dma_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic              cpu_write = 1'b0, dma_write = 1'b0;
  logic [1:0]        cpu_width = '0, dma_width = '0;
  logic              cpu_ack, dma_ack;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_read, bus_write;
  logic [1:0]        bus_width;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy;
  logic [1:0]        dbg_state;

  io_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_mem(clk_mem), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write(cpu_write), .cpu_width(cpu_width), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_write(dma_write), .dma_width(dma_width), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read(bus_read), .bus_write(bus_write),
    .bus_width(bus_width), .bus_rdata(bus_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_mem = ~clk_mem;

  // ---------------- register file model ----------------
  logic [DATA_W-1:0] mem [256];
  assign bus_rdata = mem[bus_addr[9:2]];
  always @(posedge clk_mem) begin
    if (bus_write) mem[bus_addr[9:2]] <= bus_wdata;
  end

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- grant model ----------------
  // who = 0 nobody, 1 CPU, 2 DMA. Next owner: any requester other than the
  // one just served is eligible, DMA preferred.
  int who = 0;
  always @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      who <= 0;
    end else begin
      if (dma_req && who != 2)      who <= 2;
      else if (cpu_req && who != 1) who <= 1;
      else                          who <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [ADDR_W-1:0] exp_q_cpu[$];
  logic [ADDR_W-1:0] exp_q_dma[$];

  always @(negedge clk_mem) begin
    logic              e_cack, e_dack, e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_crd, e_drd;
    logic [1:0]        e_width;
    logic [ADDR_W-1:0] q_addr;
    e_cack = (who == 1);
    e_dack = (who == 2);
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_width = '0;
    e_crd = '0; e_drd = '0;
    if (who == 1) begin
      e_rd = ~cpu_write; e_wr = cpu_write; e_addr = cpu_addr;
      e_wdata = cpu_wdata; e_width = cpu_width; e_crd = mem[cpu_addr[9:2]];
    end else if (who == 2) begin
      e_rd = ~dma_write; e_wr = dma_write; e_addr = dma_addr;
      e_wdata = dma_wdata; e_width = dma_width; e_drd = mem[dma_addr[9:2]];
    end
    chk("ctrl{cack,dack,rd,wr,busy}", {cpu_ack, dma_ack, bus_read, bus_write, busy},
        {e_cack, e_dack, e_rd, e_wr, (who != 0)});
    chk("bus_addr", bus_addr, e_addr);
    chk("bus_wdata", bus_wdata, e_wdata);
    chk("bus_width", bus_width, e_width);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dma_rdata", dma_rdata, e_drd);
    if (cpu_ack) begin
      q_addr = (exp_q_cpu.size() > 0) ? exp_q_cpu.pop_front() : 'x;
      chk("sb_cpu_addr", bus_addr, q_addr);
    end
    if (dma_ack) begin
      q_addr = (exp_q_dma.size() > 0) ? exp_q_dma.pop_front() : 'x;
      chk("sb_dma_addr", bus_addr, q_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit is_dma, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic w, input logic [1:0] wd);
    if (is_dma) begin
      dma_addr = a; dma_wdata = d; dma_write = w; dma_width = wd; dma_req = 1'b1;
      exp_q_dma.push_back(a);
    end else begin
      cpu_addr = a; cpu_wdata = d; cpu_write = w; cpu_width = wd; cpu_req = 1'b1;
      exp_q_cpu.push_back(a);
    end
  endtask

  task automatic drop(input bit is_dma);
    if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
  endtask

  // Returns at the negedge inside the ack cycle.
  task automatic wait_ack(input bit is_dma);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_mem);
      ok = is_dma ? dma_ack : cpu_ack;
    end
    chk(is_dma ? "dma_ack_timeout" : "cpu_ack_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic run_master(input bit is_dma, input int n, input int gap_max);
    int gap;
    for (int i = 0; i < n; i++) begin
      issue(is_dma, ADDR_W'($urandom), $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      wait_ack(is_dma);
      @(posedge clk_mem); #1;
      gap = $urandom_range(0, gap_max);
      if (i == n - 1 || gap != 0) drop(is_dma);
      for (int k = 0; k < gap; k++) begin
        @(posedge clk_mem); #1;
      end
    end
  endtask

  logic [33:0] seq, seq_exp;
  logic [15:0] st, st_exp;

  task automatic record_contention();
    @(posedge clk_mem);
    seq = '0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_mem);
      seq = {seq[31:0], dma_ack, cpu_ack};
    end
  endtask

  task automatic record_single();
    @(posedge clk_mem);
    st = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_mem);
      st = {st[13:0], dma_ack, busy};
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0101 * i;
    mem[8'h4C] = 32'h0000_03FF;
    mem[8'h50] = 32'h1111_1111;

    // Reset held with both requests pending.
    issue(1'b0, 24'h000010, 32'hA5A5_0001, 1'b1, 2'b10);
    issue(1'b1, 24'h000020, 32'h5A5A_0002, 1'b0, 2'b10);
    repeat (3) @(posedge clk_mem);
    @(negedge clk_mem);
    chk("rst_outputs", {cpu_ack, dma_ack, bus_read, bus_write, busy}, 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    @(posedge clk_mem); #1;
    rst_n = 1'b1;
    @(negedge clk_mem);
    chk("rel_cycle1_idle", {dma_ack, cpu_ack, busy}, 64'b000);
    @(negedge clk_mem);
    chk("rel_cycle2_dma", {dma_ack, cpu_ack}, 64'b10);
    chk("model_who_dma", who, 64'd2);
    @(posedge clk_mem); #1;
    drop(1'b1);
    @(negedge clk_mem);
    chk("rel_cycle3_cpu", {dma_ack, cpu_ack}, 64'b01);
    @(posedge clk_mem); #1;
    drop(1'b0);
    @(negedge clk_mem);
    chk("rel_back_idle", busy, 64'd0);

    // Single CPU write.
    @(posedge clk_mem); #1;
    issue(1'b0, 24'h000100, 32'h0080_0005, 1'b1, 2'b10);
    wait_ack(1'b0);
    chk("wr_strobes", {bus_write, bus_read}, 64'b10);
    chk("wr_addr", bus_addr, 64'h000100);
    chk("wr_wdata", bus_wdata, 64'h0080_0005);
    chk("wr_width", bus_width, 64'b10);
    @(posedge clk_mem); #1;
    drop(1'b0);
    chk("wr_committed", mem[8'h40], 64'h0080_0005);
    @(negedge clk_mem);
    chk("wr_one_ack_idle", {cpu_ack, busy}, 64'b00);

    // CPU read.
    @(posedge clk_mem); #1;
    issue(1'b0, 24'h000130, 32'h0, 1'b0, 2'b10);
    wait_ack(1'b0);
    chk("rd_rdata", cpu_rdata, 64'h0000_03FF);
    chk("rd_strobes", {bus_read, bus_write}, 64'b10);
    @(posedge clk_mem); #1;
    drop(1'b0);
    @(negedge clk_mem);
    chk("rd_rdata_after", cpu_rdata, 64'd0);

    // Contention: 8 back-to-back requests from each master.
    @(posedge clk_mem); #1;
    fork
      run_master(1'b0, 8, 0);
      run_master(1'b1, 8, 0);
      record_contention();
    join
    seq_exp = '0;
    for (int i = 0; i < 16; i++) seq_exp = {seq_exp[31:0], (i % 2 == 0) ? 2'b10 : 2'b01};
    seq_exp = {seq_exp[31:0], 2'b00};
    chk("contention_seq", seq, seq_exp);

    // DMA streaming alone.
    @(posedge clk_mem); #1;
    fork
      run_master(1'b1, 4, 0);
      record_single();
    join
    chk("dma_stream_ack_busy", st, 64'b11_00_11_00_11_00_11_00);

    // Reset during a CPU write.
    @(posedge clk_mem); #1;
    issue(1'b0, 24'h000140, 32'hDEAD_BEEF, 1'b1, 2'b10);
    wait_ack(1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_drop", {cpu_ack, bus_write, busy}, 64'b000);
    drop(1'b0);
    @(posedge clk_mem); #1;
    chk("abort_no_commit", mem[8'h50], 64'h1111_1111);
    rst_n = 1'b1;

    // Random traffic from both masters.
    @(posedge clk_mem); #1;
    fork
      run_master(1'b0, 40, 3);
      run_master(1'b1, 40, 3);
    join
    repeat (3) @(posedge clk_mem);
    chk("sb_drained", {32'(exp_q_cpu.size()), 32'(exp_q_dma.size())}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
